// File: rtl/alu_res_collect_pkg.sv
// Shared types for the ALU result collector: COASZP flag layout, buffered
// entry format and the parity helper.
package alu_res_collect_pkg;

  // Field order fixes the architectural bit positions: C=5 O=4 A=3 S=2 Z=1 P=0.
  typedef struct packed {
    logic c;
    logic o;
    logic a;
    logic s;
    logic z;
    logic p;
  } flags_t;

  localparam int FLAGS_W = $bits(flags_t);
  localparam int VAL_W   = 65;

  typedef struct packed {
    logic [VAL_W-1:0] value;
    flags_t           flags;
    logic             has_flags;
    logic             perr;
  } entry_t;

  // Even parity: bit 65 must equal the XOR of the 65 value bits.
  function automatic logic parity_err(input logic [VAL_W:0] d);
    return d[VAL_W] ^ (^d[VAL_W-1:0]);
  endfunction

endpackage

// File: rtl/alu_res_collect_fifo_ctl.sv
// Pointer/count bookkeeping for the result FIFO; flush has priority over
// push and pop. Callers gate push with ~full and pop with ~empty.
module res_fifo_ctl #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH)-1:0] wr_ptr,
  output logic [$clog2(DEPTH)-1:0] rd_ptr,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CW-1:0] count;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/alu_res_collect.sv
// ALU result collector: buffers results in a small FIFO for writeback and
// maintains the COASZP flags register. Parity checking is enabled by ALU_RES_PARITY_EN.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

module alu_res_collect
  import alu_res_collect_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int REG_WIDTH = `REG_ADDR_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 except,
  input  logic                 res_valid,
  output logic                 res_ready,
  input  logic [VAL_W:0]       res_data,
  input  logic [FLAGS_W-1:0]   res_flags,
  input  logic                 res_has_flags,
  input  logic [REG_WIDTH-1:0] res_reg,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [VAL_W-1:0]     wb_data,
  output logic [REG_WIDTH-1:0] wb_reg,
  output logic                 wb_perr,
  output logic [FLAGS_W-1:0]   flags_out,
  output logic                 perr_sticky
);
  localparam int PW = $clog2(DEPTH);

  logic          push, pop, full, empty;
  logic [PW-1:0] wr_ptr, rd_ptr;
  entry_t        in_e, head;

  entry_t               mem     [DEPTH];
  logic [REG_WIDTH-1:0] mem_reg [DEPTH];

  assign res_ready = ~full;
  assign wb_valid  = ~empty;
  assign push      = res_valid & ~full;
  assign pop       = wb_ready & ~empty;

  res_fifo_ctl #(.DEPTH(DEPTH)) u_ctl (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .flush  (except),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .full   (full),
    .empty  (empty)
  );

  always_comb begin
    in_e           = '0;
    in_e.value     = res_data[VAL_W-1:0];
    in_e.flags     = flags_t'(res_flags);
    in_e.has_flags = res_has_flags;
`ifdef ALU_RES_PARITY_EN
    in_e.perr      = parity_err(res_data);
`else
    in_e.perr      = 1'b0;
`endif
  end

  // Storage is deliberately unreset; it is only observable while non-empty.
  always_ff @(posedge clk) begin
    if (push & ~except) begin
      mem[wr_ptr]     <= in_e;
      mem_reg[wr_ptr] <= res_reg;
    end
  end

  assign head    = mem[rd_ptr];
  assign wb_data = head.value;
  assign wb_reg  = mem_reg[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      flags_out <= '0;
    else if (pop & ~except & head.has_flags & ~head.perr)
      flags_out <= head.flags;
  end

`ifdef ALU_RES_PARITY_EN
  assign wb_perr = wb_valid & head.perr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      perr_sticky <= 1'b0;
    else if (push & ~except & in_e.perr)
      perr_sticky <= 1'b1;
  end
`else
  logic unused_par;
  assign unused_par  = res_data[VAL_W];
  assign wb_perr     = 1'b0;
  assign perr_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_alu_res_collect.sv
// Scoreboard bench for alu_res_collect: a queue-based reference model tracks
// accepted results, a negedge monitor compares every visible output.
module tb_alu_res_collect;
  localparam int DEPTH = 4;
  localparam int RW    = 5;

  logic          clk = 1'b0;
  logic          rst, except, res_valid, res_ready, res_has_flags;
  logic          wb_valid, wb_ready, wb_perr, perr_sticky;
  logic [65:0]   res_data;
  logic [5:0]    res_flags, flags_out;
  logic [RW-1:0] res_reg, wb_reg;
  logic [64:0]   wb_data;

  alu_res_collect #(.DEPTH(DEPTH), .REG_WIDTH(RW)) dut (
    .clk           (clk),
    .rst           (rst),
    .except        (except),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .res_flags     (res_flags),
    .res_has_flags (res_has_flags),
    .res_reg       (res_reg),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_data       (wb_data),
    .wb_reg        (wb_reg),
    .wb_perr       (wb_perr),
    .flags_out     (flags_out),
    .perr_sticky   (perr_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [64:0]   v;
    logic [RW-1:0] r;
    logic [5:0]    f;
    bit            h;
    bit            pe;
  } item_t;

  item_t      q[$];
  item_t      m_it;
  int         m_n;
  logic [5:0] m_flags  = '0;
  bit         m_sticky = 1'b0;
  bit         mon_en   = 1'b0;
  int         checks   = 0;
  int         failures = 0;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit exp_perr(input logic [65:0] d);
`ifdef ALU_RES_PARITY_EN
    return (d[65] != (^d[64:0]));
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: FIFO of accepted results, flags follow clean has_flags pops.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_flags  = '0;
      m_sticky = 1'b0;
    end else if (except) begin
      q.delete();
    end else begin
      m_n = q.size();
      if (wb_ready && m_n > 0) begin
        m_it = q.pop_front();
        if (m_it.h && !m_it.pe) m_flags = m_it.f;
      end
      if (res_valid && m_n < DEPTH) begin
        m_it.v  = res_data[64:0];
        m_it.r  = res_reg;
        m_it.f  = res_flags;
        m_it.h  = res_has_flags;
        m_it.pe = exp_perr(res_data);
        q.push_back(m_it);
        if (m_it.pe) m_sticky = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("wb_valid", 65'(wb_valid), 65'(q.size() > 0));
      chk("res_ready", 65'(res_ready), 65'(q.size() < DEPTH));
      chk("flags_out", 65'(flags_out), 65'(m_flags));
      chk("perr_sticky", 65'(perr_sticky), 65'(m_sticky));
      if (q.size() > 0) begin
        chk("wb_data", wb_data, q[0].v);
        chk("wb_reg", 65'(wb_reg), 65'(q[0].r));
        chk("wb_perr", 65'(wb_perr), 65'(q[0].pe));
      end else begin
        chk("wb_perr_empty", 65'(wb_perr), 65'(0));
      end
    end
  end

  // Holds the inputs across exactly one rising edge; returns at negedge+1.
  task automatic drive(input bit v, input logic [64:0] val, input bit bad,
                       input logic [5:0] f, input bit h, input bit rdy, input bit ex);
    res_valid     = v;
    res_data      = {(^val) ^ bad, val};
    res_flags     = f;
    res_has_flags = h;
    res_reg       = RW'($urandom);
    wb_ready      = rdy;
    except        = ex;
    @(negedge clk);
    #1;
  endtask

  function automatic logic [64:0] rval();
    return {1'($urandom), $urandom, $urandom};
  endfunction

  initial begin
    rst = 1'b1; except = 1'b0; res_valid = 1'b0; res_data = '0;
    res_flags = '0; res_has_flags = 1'b0; res_reg = '0; wb_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_res_ready", 65'(res_ready), 65'(1));
    chk("rst_wb_valid", 65'(wb_valid), 65'(0));
    chk("rst_wb_perr", 65'(wb_perr), 65'(0));
    chk("rst_flags_out", 65'(flags_out), 65'(0));
    chk("rst_perr_sticky", 65'(perr_sticky), 65'(0));
    #1 rst = 1'b0;
    mon_en = 1'b1;

    // Known-good parity, then the same value with a corrupted parity bit.
    drive(1, 65'h1_0000_0000_0000_0001, 0, 6'h15, 0, 0, 0);
    drive(0, '0, 0, '0, 0, 1, 0);
    drive(1, 65'h1_0000_0000_0000_0001, 1, 6'h3F, 1, 0, 0);
    drive(0, '0, 0, '0, 0, 1, 0);
    drive(0, '0, 0, '0, 0, 0, 0);

    // Fill past full with writeback stalled, then drain.
    repeat (6) drive(1, rval(), 0, 6'($urandom), 1'($urandom), 0, 0);
    repeat (6) drive(0, '0, 0, '0, 0, 1, 0);

    // Three buffered, then steady push+pop for 10 cycles.
    repeat (3) drive(1, rval(), 0, 6'($urandom), 1'($urandom), 0, 0);
    repeat (10) drive(1, rval(), 0, 6'($urandom), 1'($urandom), 1, 0);
    repeat (4) drive(0, '0, 0, '0, 0, 1, 0);

    // Flush with three buffered while a push and pop are also offered.
    repeat (3) drive(1, rval(), 0, 6'($urandom), 1, 0, 0);
    drive(1, rval(), 0, 6'h3F, 1, 1, 1);
    drive(0, '0, 0, '0, 0, 0, 0);

    repeat (1500)
      drive(($urandom % 4) != 0, rval(), ($urandom % 8) == 0, 6'($urandom),
            1'($urandom), ($urandom % 3) != 0, ($urandom % 40) == 0);

    // Make flags_out non-zero, buffer a burst, then reset between edges.
    drive(0, '0, 0, '0, 0, 1, 0);
    drive(0, '0, 0, '0, 0, 1, 0);
    drive(0, '0, 0, '0, 0, 1, 0);
    drive(0, '0, 0, '0, 0, 1, 0);
    drive(1, rval(), 0, 6'h2A, 1, 0, 0);
    drive(0, '0, 0, '0, 0, 1, 0);
    chk("pre_rst_flags", 65'(flags_out), 65'(6'h2A));
    repeat (3) drive(1, rval(), 0, 6'h11, 1, 0, 0);
    res_valid = 1'b1; wb_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("async_wb_valid", 65'(wb_valid), 65'(0));
    chk("async_flags_out", 65'(flags_out), 65'(0));
    chk("async_res_ready", 65'(res_ready), 65'(1));
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (20) drive(1, rval(), 0, 6'($urandom), 1'($urandom), 1'($urandom), 0);
    repeat (5) drive(0, '0, 0, '0, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
